sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//   Responder end of the cache-to-SRAM request/ready protocol. Accepts one
//   line-read (64b, two 32b words) or one word-write (32b) per request.
//   Sequences it as 16-bit accesses on the external asynchronous SRAM chip.
//   Returns the assembled line on SRAM_data with a one-cycle SRAM_ready pulse.
// PARAMETERS
//   ACCESS_CYCLES  2   clocks per 16-bit SRAM access; legal range 2..15
// PORTS
//   clk             in     1   system clock, rising edge
//   rst             in     1   asynchronous, active-high reset
//   address         in     16  32-bit-word address from cache controller
//   write_data      in     32  word to store; sampled with the write request
//   SRAM_mem_read   in     1   line-read request, held until SRAM_ready
//   SRAM_mem_write  in     1   word-write request, held until SRAM_ready
//   SRAM_data       out    64  registered read line, {w1,w0} = {odd,even word}
//   SRAM_ready      out    1   one-cycle completion pulse (read or write)
//   SRAM_ADDR       out    18  half-word address to chip
//   SRAM_DQ         inout  16  chip data bus
//   SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  chip strobes, active low
// BEHAVIOUR
// - One clock domain, clk. Reset is asynchronous and active-high.
// - Reset values:
//   - SRAM_ready=0, SRAM_data=0, SRAM_ADDR=0, WE_N=OE_N=CE_N=1, UB_N=LB_N=0.
//   - DQ is high-Z; FSM is in IDLE; beat and cycle counters are 0.
// - FSM states: IDLE, READ, WRITE, DONE.
//   - IDLE: samples requests on each edge.
//     - write=1 -> WRITE. A write wins when read and write are both high.
//     - read=1 alone -> READ.
//     - On leaving IDLE, latch address and write_data into internal registers.
//       Later input changes are ignored until the next IDLE.
//   - READ: 4 beats of ACCESS_CYCLES clocks each.
//     - Beat k drives SRAM_ADDR = {1'b0, addr[15:1], k[1:0]}.
//     - CE_N=0, OE_N=0, WE_N=1, DQ high-Z.
//     - Capture DQ into shadow[16k+15:16k] on the edge that ends beat k.
//     - After beat 3 -> DONE. On that same edge, copy shadow to SRAM_data.
//   - WRITE: 2 beats of ACCESS_CYCLES clocks each.
//     - Beat k drives SRAM_ADDR = {1'b0, addr[15:0], k[0]}.
//     - DQ = wdata[16k+15:16k]; CE_N=0, OE_N=1.
//     - WE_N=0 for the first ACCESS_CYCLES-1 clocks of the beat and 1 on the
//       last clock, so data hold is met.
//     - After beat 1 -> DONE. SRAM_data is unchanged by a write.
//   - DONE: SRAM_ready=1 (Moore output), CE_N=1, DQ high-Z -> IDLE unconditionally.
// - Latency, counted from the IDLE edge that samples the request:
//   - Read: SRAM_ready is high in clock 4*ACCESS_CYCLES+1.
//   - Write: SRAM_ready is high in clock 2*ACCESS_CYCLES+1.
// - SRAM_data stays valid from the DONE cycle until the next read's DONE edge.
//   The requester may use it combinationally during the ready cycle.
// - The requester deasserts its request on the edge where it sees SRAM_ready=1.
//   The first IDLE cycle after DONE therefore samples the new request level.
//   A request still high in that cycle starts a new transaction.
// - Counters:
//   - cycle counter is 4 bits and wraps to 0 at ACCESS_CYCLES-1.
//   - beat counter is 2 bits and clears on entry to READ or WRITE.
// - Reset mid-transaction:
//   - Aborts immediately to reset values; no SRAM_ready is issued.
//   - Any write half already issued stays in the chip (no rollback).
//   - SRAM_data returns to 0.
// - UB_N and LB_N are tied active (full 16-bit accesses only).
// TESTING  (ACCESS_CYCLES=2, behavioural SRAM model returns the half-word address as data)
// 1 Read address=16'h0005
//   -> SRAM_ADDR 0x8,0x9,0xA,0xB for 2 clocks each.
//   -> Ready in clock 9 with SRAM_data=64'h000B_000A_0009_0008.
// 2 Write address=16'h0003, write_data=32'hDEADBEEF
//   -> ADDR 0x6 with DQ=BEEF, then ADDR 0x7 with DQ=DEAD.
//   -> WE_N pattern 0,1,0,1; ready in clock 5.
//   -> A following read of 0x0002 returns w1=32'hDEADBEEF.
// 3 Read and write high together (write 0x0001/32'h12345678)
//   -> The write path executes, OE_N stays 1, SRAM_data is unchanged.
// 4 Back-to-back: read A, request dropped on ready, read B raised one cycle later
//   -> Exactly two ready pulses.
//   -> SRAM_data holds A until B's DONE edge.
// 5 rst asserted during READ beat 2
//   -> All outputs take reset values asynchronously, no ready pulse.
//   -> The next read completes normally in 9 clocks.
// 6 Address change during READ
//   -> SRAM_ADDR follows the latched address only.

Source files
------------

// File: rtl/sram_controller_if.sv
// Cache-side request/ready bus between a cache controller (master) and the SRAM
// controller (slave).
// Handshake: the master holds SRAM_mem_read or SRAM_mem_write with address and
// write_data stable until it sees SRAM_ready=1. It drops the request on that
// same edge. SRAM_ready is a one-cycle pulse, and SRAM_data is valid from that
// cycle until the next read completes.
interface sram_controller_if;
  logic [15:0] address;
  logic [31:0] write_data;
  logic        SRAM_mem_read;
  logic        SRAM_mem_write;
  logic [63:0] SRAM_data;
  logic        SRAM_ready;

  modport master (
    output address, write_data, SRAM_mem_read, SRAM_mem_write,
    input  SRAM_data, SRAM_ready
  );

  modport slave (
    input  address, write_data, SRAM_mem_read, SRAM_mem_write,
    output SRAM_data, SRAM_ready
  );
endinterface

// File: rtl/sram_controller.sv
// Turns cache line-reads (4 x 16b) and word-writes (2 x 16b) into timed accesses
// on an external asynchronous 16-bit SRAM chip.
module sram_controller #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  sram_controller_if.slave        bus,
  output logic [17:0]             SRAM_ADDR,
  inout  wire  [15:0]             SRAM_DQ,
  output logic                    SRAM_WE_N,
  output logic                    SRAM_OE_N,
  output logic                    SRAM_CE_N,
  output logic                    SRAM_UB_N,
  output logic                    SRAM_LB_N,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cycle_q, cycle_d;
  logic [1:0]  beat_q, beat_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [47:0] shadow_q, shadow_d;
  logic [63:0] data_q, data_d;
  logic        last_cycle;
  logic        dq_oe;
  logic [15:0] dq_out;

  assign last_cycle = (cycle_q == 4'(ACCESS_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cycle_q  <= '0;
      beat_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        cycle_d = '0;
        beat_d  = '0;
        // Write has priority when both requests are raised together.
        if (bus.SRAM_mem_write) begin
          state_d = WRITE;
          addr_d  = bus.address;
          wdata_d = bus.write_data;
        end else if (bus.SRAM_mem_read) begin
          state_d = READ;
          addr_d  = bus.address;
          wdata_d = bus.write_data;
        end
      end
      READ: begin
        if (last_cycle) begin
          cycle_d = '0;
          if (beat_q == 2'd3) begin
            data_d  = {SRAM_DQ, shadow_q};
            beat_d  = '0;
            state_d = DONE;
          end else begin
            shadow_d[{beat_q, 4'b0000} +: 16] = SRAM_DQ;
            beat_d = beat_q + 2'd1;
          end
        end else begin
          cycle_d = cycle_q + 4'd1;
        end
      end
      WRITE: begin
        if (last_cycle) begin
          cycle_d = '0;
          if (beat_q == 2'd1) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          cycle_d = cycle_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_CE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = '0;
    case (state_q)
      READ: begin
        SRAM_ADDR = {1'b0, addr_q[15:1], beat_q};
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b0;
      end
      WRITE: begin
        SRAM_ADDR = {1'b0, addr_q, beat_q[0]};
        SRAM_CE_N = 1'b0;
        dq_oe     = 1'b1;
        dq_out    = beat_q[0] ? wdata_q[31:16] : wdata_q[15:0];
        // WE_N rises one clock before address/data move, giving data hold.
        SRAM_WE_N = last_cycle;
      end
      default: ;
    endcase
  end

  assign SRAM_DQ       = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_UB_N     = 1'b0;
  assign SRAM_LB_N     = 1'b0;
  assign bus.SRAM_data  = data_q;
  assign bus.SRAM_ready = (state_q == DONE);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM whose
// initial contents equal the half-word address.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
  logic [1:0]  state_dbg;

  sram_controller_if bus ();

  sram_controller #(.ACCESS_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: latches data on the rising edge of WE_N.
  logic [15:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;
  always @(posedge SRAM_WE_N) if (SRAM_CE_N === 1'b0) mem[SRAM_ADDR[9:0]] = SRAM_DQ;

  // Scoreboard
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  logic [63:0] last_data = '0;

  logic [17:0] addr_tr [0:15];
  logic        we_tr   [0:15];
  logic        oe_tr   [0:15];
  logic [15:0] dq_tr   [0:15];
  logic [63:0] data_tr [0:15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.SRAM_ready === 1'b1) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got data %h with no pending request", bus.SRAM_data);
      end else begin
        chk("ready_data", bus.SRAM_data, exp_q.pop_front());
      end
    end
  end

  // Driver: call at a negedge; returns at the negedge that sees SRAM_ready.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [31:0] wd, input int chg_at,
                         input logic [15:0] chg_a, output int lat);
    bus.address        = a;
    bus.write_data     = wd;
    bus.SRAM_mem_read  = rd;
    bus.SRAM_mem_write = wr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat < 16) begin
        addr_tr[lat] = SRAM_ADDR;
        we_tr[lat]   = SRAM_WE_N;
        oe_tr[lat]   = SRAM_OE_N;
        dq_tr[lat]   = SRAM_DQ;
        data_tr[lat] = bus.SRAM_data;
      end
      if (lat == chg_at) bus.address = chg_a;
    end while (bus.SRAM_ready !== 1'b1 && lat < 64);
    bus.SRAM_mem_read  = 1'b0;
    bus.SRAM_mem_write = 1'b0;
    if (bus.SRAM_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: no ready after %0d clocks, expected one", lat);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [63:0] exp,
                         input int chg_at, input logic [15:0] chg_a, output int lat);
    exp_q.push_back(exp);
    last_data = exp;
    run_txn(1'b1, 1'b0, a, 32'h0, chg_at, chg_a, lat);
  endtask

  task automatic do_write(input logic rd, input logic [15:0] a, input logic [31:0] wd, output int lat);
    exp_q.push_back(last_data);
    run_txn(rd, 1'b1, a, wd, 0, 16'h0, lat);
  endtask

  initial begin
    int lat;
    int rc0;
    logic [17:0] exp_rd [1:8];
    bus.address = '0; bus.write_data = '0;
    bus.SRAM_mem_read = 1'b0; bus.SRAM_mem_write = 1'b0;
    rst = 1'b1;
    #12;
    chk("rst_ready", {63'b0, bus.SRAM_ready}, 64'd0);
    chk("rst_data", bus.SRAM_data, 64'd0);
    chk("rst_addr", {46'b0, SRAM_ADDR}, 64'd0);
    chk("rst_strobes", {59'b0, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 64'b11100);
    chk("rst_state", {62'b0, state_dbg}, 64'd0);
    checks++;
    if (SRAM_DQ !== 16'hzzzz) begin errors++; $display("FAIL rst_dq: got %h expected zzzz", SRAM_DQ); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // 1: line read of word 5
    do_read(16'h0005, 64'h000B_000A_0009_0008, 0, 16'h0, lat);
    chk("t1_latency", 64'(lat), 64'd9);
    exp_rd = '{18'h8, 18'h8, 18'h9, 18'h9, 18'hA, 18'hA, 18'hB, 18'hB};
    for (int i = 1; i <= 8; i++) chk($sformatf("t1_addr%0d", i), 64'(addr_tr[i]), 64'(exp_rd[i]));
    chk("t1_oe", {63'b0, oe_tr[4]}, 64'd0);
    @(negedge clk);

    // 2: word write then read back
    do_write(1'b0, 16'h0003, 32'hDEADBEEF, lat);
    chk("t2_latency", 64'(lat), 64'd5);
    chk("t2_addr", {addr_tr[1][15:0], addr_tr[2][15:0], addr_tr[3][15:0], addr_tr[4][15:0]}, 64'h0006_0006_0007_0007);
    chk("t2_we", {60'b0, we_tr[1], we_tr[2], we_tr[3], we_tr[4]}, 64'b0101);
    chk("t2_dq", {dq_tr[1], dq_tr[2], dq_tr[3], dq_tr[4]}, 64'hBEEF_BEEF_DEAD_DEAD);
    @(negedge clk);
    do_read(16'h0002, 64'hDEADBEEF_0005_0004, 0, 16'h0, lat);
    @(negedge clk);

    // 3: read and write together -> write wins, data unchanged
    do_write(1'b1, 16'h0001, 32'h12345678, lat);
    chk("t3_latency", 64'(lat), 64'd5);
    chk("t3_oe", {60'b0, oe_tr[1], oe_tr[2], oe_tr[3], oe_tr[4]}, 64'b1111);
    chk("t3_mem", {32'b0, mem[3], mem[2]}, 64'h12345678);
    @(negedge clk);

    // 4: back-to-back reads, B raised one cycle after A's ready
    rc0 = ready_cnt;
    do_read(16'h0000, 64'h1234_5678_0001_0000, 0, 16'h0, lat);
    @(negedge clk);
    do_read(16'h0004, 64'h000B_000A_0009_0008, 0, 16'h0, lat);
    chk("t4_hold_a", data_tr[8], 64'h1234_5678_0001_0000);
    chk("t4_latency", 64'(lat), 64'd9);
    @(negedge clk);
    chk("t4_ready_pulses", 64'(ready_cnt - rc0), 64'd2);

    // 5: reset during READ beat 2
    bus.address = 16'h0006;
    bus.SRAM_mem_read = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_beat2_addr", 64'(SRAM_ADDR), 64'hE);
    rst = 1'b1;
    #1;
    chk("t5_rst_data", bus.SRAM_data, 64'd0);
    chk("t5_rst_addr", 64'(SRAM_ADDR), 64'd0);
    chk("t5_rst_strobes", {61'b0, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N}, 64'b111);
    chk("t5_rst_ready", {63'b0, bus.SRAM_ready}, 64'd0);
    bus.SRAM_mem_read = 1'b0;
    last_data = '0;
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    do_read(16'h0006, 64'h000F_000E_000D_000C, 0, 16'h0, lat);
    chk("t5_latency", 64'(lat), 64'd9);
    @(negedge clk);

    // 6: address change mid-read must not reach the chip
    do_read(16'h0007, 64'h000F_000E_000D_000C, 3, 16'h00FF, lat);
    chk("t6_addr", {addr_tr[2][15:0], addr_tr[4][15:0], addr_tr[6][15:0], addr_tr[8][15:0]}, 64'h000C_000D_000E_000F);
    repeat (4) @(negedge clk);

    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
